// File: rtl/mult_pkg.sv
// Shared definitions for the sequential shift-and-add multiplier:
// controller state encoding and default operand geometry.
package mult_pkg;

  localparam int unsigned DEFAULT_WIDTH = 5;
  localparam int unsigned DEFAULT_CNT_W = 3;

  // 2'd3 is never entered; the controller decodes it back to IDLE.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/adder_2w.sv
// Ripple-carry adder, 2*WIDTH bits wide, purely combinational.
// Carry into bit 0 is zero; CO is the carry out of the top bit.
module adder_2w #(
  parameter int WIDTH = 5
) (
  input  logic [2*WIDTH-1:0] A,
  input  logic [2*WIDTH-1:0] B,
  output logic [2*WIDTH-1:0] S,
  output logic               CO
);

  logic [2*WIDTH:0] carry;

  assign carry[0] = 1'b0;

  // One full adder per bit; each carry is formed from that bit's own operands.
  for (genvar i = 0; i < 2*WIDTH; i++) begin : g_bit
    assign S[i]       = A[i] ^ B[i] ^ carry[i];
    assign carry[i+1] = (A[i] & B[i]) | (carry[i] & (A[i] ^ B[i]));
  end

  assign CO = carry[2*WIDTH];

endmodule

// File: rtl/mult_seq_ctrl.sv
// Sequential unsigned multiplier: one accumulate step per cycle over WIDTH
// cycles using a single shared 2*WIDTH-bit adder.
//
// Handshake: start is sampled only while ready=1; the edge that sees
// ready=1 and start=1 is the accept. busy is always ~ready. done pulses for
// exactly one cycle when product becomes valid; product then holds until the
// next operation completes. start while busy is ignored.
module mult_seq_ctrl
  import mult_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic                 CLOCK_50,
  input  logic                 RESET_N,
  input  logic                 start,
  input  logic [WIDTH-1:0]     op_a,
  input  logic [WIDTH-1:0]     op_b,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output state_t               dbg_state
);

  state_t               state_q;
  logic [2*WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]     b_q;
  logic [2*WIDTH-1:0]   acc_q;
  logic [CNT_W-1:0]     cnt_q;
  logic                 ready_q;
  logic                 busy_q;
  logic                 done_q;
  logic [2*WIDTH-1:0]   product_q;

  logic [2*WIDTH-1:0]   addend_d;
  logic [2*WIDTH-1:0]   sum_d;
  logic                 carry_d;

  // Partial product for the current step: shifted multiplicand or zero.
  always_comb begin
    addend_d = '0;
    if (b_q[cnt_q]) addend_d = a_q << cnt_q;
  end

  adder_2w #(.WIDTH(WIDTH)) u_adder (
    .A  (acc_q),
    .B  (addend_d),
    .S  (sum_d),
    .CO (carry_d)
  );

  // The largest product fits in 2*WIDTH bits, so the adder never carries out.
  a_no_carry : assert property (@(posedge CLOCK_50) disable iff (!RESET_N)
                                (state_q == ST_RUN) |-> !carry_d);

  // Controller: state, operand/accumulator registers and registered outputs.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= ST_IDLE;
      a_q       <= '0;
      b_q       <= '0;
      acc_q     <= '0;
      cnt_q     <= '0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            a_q     <= {{WIDTH{1'b0}}, op_a};
            b_q     <= op_b;
            acc_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_q <= sum_d;
          cnt_q <= cnt_q + CNT_W'(1);
          // Fixed-length run: no early exit even if b has no bits left.
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            product_q <= sum_d;
            done_q    <= 1'b1;
            state_q   <= ST_DONE;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign ready     = ready_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign product   = product_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Testbench for mult_seq_ctrl: table-driven single operations with latency
// and handshake checks, randomized operations against a product model,
// asynchronous mid-run reset, and back-to-back streams with a scoreboard.
module tb_mult_seq_ctrl;
  import mult_pkg::*;

  localparam int WIDTH = 5;
  localparam int CNT_W = 3;
  localparam int PW    = 2*WIDTH;

  logic           CLOCK_50;
  logic           RESET_N;
  logic           start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic           ready;
  logic           busy;
  logic           done;
  logic [PW-1:0]  product;
  state_t         dbg_state;

  mult_seq_ctrl #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLOCK_50  (CLOCK_50),
    .RESET_N   (RESET_N),
    .start     (start),
    .op_a      (op_a),
    .op_b      (op_b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .product   (product),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial CLOCK_50 = 1'b0;
  always #5 CLOCK_50 = ~CLOCK_50;

  int cyc = 0;
  always @(posedge CLOCK_50) cyc <= cyc + 1;

  // ---------------- bookkeeping ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PW-1:0] exp_q[$];
  logic [PW-1:0] last_prod = '0;
  bit  inv_en  = 0;
  bit  sb_en   = 0;
  bit  have_prev = 0;
  int  last_done_cyc = 0;
  int  done_cnt = 0;
  int  accepts  = 0;
  int  stim_a[$];
  int  stim_b[$];

  // Handshake invariants, checked every cycle while out of reset.
  always @(negedge CLOCK_50) begin
    if (inv_en && RESET_N) begin
      chk("ready_is_not_busy", ready ^ busy, 1);
      chk("done_ready_exclusive", done & ready, 0);
    end
  end

  // Stream monitor: every done pops one expected product; spacing is WIDTH+2.
  always @(negedge CLOCK_50) begin
    if (sb_en && RESET_N && done) begin
      done_cnt++;
      if (exp_q.size() == 0) begin
        chk("sb_unexpected_done", 1, 0);
      end else begin
        chk("sb_product", product, exp_q.pop_front());
      end
      if (have_prev) chk("sb_done_period", cyc - last_done_cyc, WIDTH + 2);
      have_prev = 1;
      last_done_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  // Waits for the accept edge, then checks every cycle up to the return to IDLE.
  // mode 0: quiet inputs; 1: start pulses with 5x5 in cycles 2 and 4;
  // 2: random start/operands while busy.
  task automatic check_op(input logic [PW-1:0] exp, input int mode);
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    op_a  = WIDTH'($urandom_range(0, 31));
    op_b  = WIDTH'($urandom_range(0, 31));
    for (int c = 1; c <= WIDTH + 2; c++) begin
      @(negedge CLOCK_50);
      if (c <= WIDTH) begin
        chk("run_ready", ready, 0);
        chk("run_busy", busy, 1);
        chk("run_done", done, 0);
        chk("run_product_hold", product, last_prod);
      end else if (c == WIDTH + 1) begin
        chk("done_pulse", done, 1);
        chk("done_ready", ready, 0);
        chk("done_busy", busy, 1);
        chk("done_product", product, exp);
      end else begin
        chk("idle_ready", ready, 1);
        chk("idle_busy", busy, 0);
        chk("idle_done", done, 0);
        chk("idle_product", product, exp);
      end
      if (c < WIDTH) begin
        case (mode)
          1: begin
            start = (c == 1) || (c == 3);
            op_a  = WIDTH'(5);
            op_b  = WIDTH'(5);
          end
          2: begin
            start = 1'($urandom_range(0, 1));
            op_a  = WIDTH'($urandom_range(0, 31));
            op_b  = WIDTH'($urandom_range(0, 31));
          end
          default: start = 1'b0;
        endcase
      end else begin
        start = 1'b0;
      end
    end
    last_prod = exp;
  endtask

  task automatic do_op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                       input logic [PW-1:0] exp, input int mode);
    @(posedge CLOCK_50);
    #1;
    start = 1'b1;
    op_a  = a;
    op_b  = b;
    check_op(exp, mode);
  endtask

  // Holds start high and feeds stim_a/stim_b one operation every WIDTH+2 edges.
  task automatic run_b2b();
    int n;
    n = stim_a.size();
    have_prev = 0;
    sb_en = 1;
    @(posedge CLOCK_50);
    #1;
    for (int i = 0; i < n; i++) begin
      start = 1'b1;
      op_a  = WIDTH'(stim_a[i]);
      op_b  = WIDTH'(stim_b[i]);
      exp_q.push_back(PW'(stim_a[i] * stim_b[i]));
      accepts++;
      @(posedge CLOCK_50);
      #1;
      if (i == n - 1) start = 1'b0;
      repeat (WIDTH + 1) @(posedge CLOCK_50);
      #1;
    end
    repeat (2) @(negedge CLOCK_50);
    sb_en = 0;
    stim_a.delete();
    stim_b.delete();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [PW-1:0]    p;
    int               mode;
  } vec_t;

  vec_t vecs[6];

  // ---------------- main sequence ----------------
  initial begin
    logic [WIDTH-1:0] ra, rb;
    start   = 1'b0;
    op_a    = '0;
    op_b    = '0;
    RESET_N = 1'b1;
    #1 RESET_N = 1'b0;
    #1;
    chk("rst_ready", ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_product", product, 0);
    repeat (2) @(negedge CLOCK_50);
    chk("rst_hold_done", done, 0);
    RESET_N = 1'b1;
    inv_en  = 1;

    vecs[0] = '{a: 5'd21, b: 5'd10, p: 10'd210, mode: 0};
    vecs[1] = '{a: 5'd31, b: 5'd31, p: 10'd961, mode: 0};
    vecs[2] = '{a: 5'd0,  b: 5'd31, p: 10'd0,   mode: 0};
    vecs[3] = '{a: 5'd31, b: 5'd0,  p: 10'd0,   mode: 0};
    vecs[4] = '{a: 5'd7,  b: 5'd3,  p: 10'd21,  mode: 1};
    vecs[5] = '{a: 5'd13, b: 5'd27, p: 10'd351, mode: 0};

    for (int i = 0; i < 6; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].mode);
      if (vecs[i].mode == 1) begin
        // No second operation may have been queued; product must stay put.
        repeat (3) begin
          @(negedge CLOCK_50);
          chk("after_pulses_ready", ready, 1);
          chk("after_pulses_done", done, 0);
          chk("after_pulses_product", product, vecs[i].p);
        end
      end
    end

    // Randomized operations with noise while busy and random idle gaps.
    for (int i = 0; i < 30; i++) begin
      ra = WIDTH'($urandom_range(0, 31));
      rb = WIDTH'($urandom_range(0, 31));
      repeat ($urandom_range(0, 3)) @(posedge CLOCK_50);
      do_op(ra, rb, PW'(int'(ra) * int'(rb)), 2);
    end

    // Asynchronous reset in the middle of a 31x31 run.
    @(posedge CLOCK_50);
    #1;
    start = 1'b1;
    op_a  = 5'd31;
    op_b  = 5'd31;
    @(posedge CLOCK_50);
    #1;
    start = 1'b0;
    @(posedge CLOCK_50);
    @(posedge CLOCK_50);
    #3;
    RESET_N = 1'b0;
    #1;
    chk("abort_product", product, 0);
    chk("abort_ready", ready, 1);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    last_prod = '0;
    repeat (3) begin
      @(negedge CLOCK_50);
      chk("abort_no_done", done, 0);
      chk("abort_hold_product", product, 0);
    end
    start = 1'b1;
    op_a  = 5'd3;
    op_b  = 5'd4;
    #2 RESET_N = 1'b1;
    check_op(10'd12, 0);
    chk("abort_no_late_done", done, 0);

    // Back-to-back with alternating operand sets.
    stim_a = '{21, 31, 21};
    stim_b = '{10, 31, 10};
    run_b2b();

    // Exhaustive sweep of every operand pair, back-to-back.
    for (int i = 0; i < 1024; i++) begin
      stim_a.push_back(i / 32);
      stim_b.push_back(i % 32);
    end
    run_b2b();

    chk("done_count", done_cnt, accepts);
    chk("sb_empty", exp_q.size(), 0);
    chk("final_product", product, 31 * 31);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
